hni_safe_fifo: RTL
==================

HNI_SAFE_FIFO -- requirements
Module: hni_safe_fifo

Interface
Parameters:
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 8: data width in bits, legal range 1 or more.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: number of entries, legal range 2 or more; any value is legal, including non-power-of-2.
REQ-003 The block SHALL have parameter AFULL_LVL, default FIFO_DEPTH-1: almost-full threshold, legal range 1..FIFO_DEPTH.
REQ-004 The block SHALL have parameter AEMPTY_LVL, default 1: almost-empty threshold, legal range 0..FIFO_DEPTH-1.
REQ-005 Local constant CNT_W SHALL equal $clog2(FIFO_DEPTH+1).

Ports (clock and reset first):
REQ-006 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  synchronous clear of FIFO contents.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_data  in  FIFO_WIDTH  write data.
REQ-011 rd_en  in  1  read request (pop).
REQ-012 err_clr  in  1  clears the sticky error flags.
REQ-013 rd_data  out  FIFO_WIDTH  head entry (show-ahead).
REQ-014 full  out  1  count == FIFO_DEPTH.
REQ-015 empty  out  1  count == 0.
REQ-016 afull  out  1  count >= AFULL_LVL.
REQ-017 aempty  out  1  count <= AEMPTY_LVL.
REQ-018 count  out  CNT_W  current occupancy.
REQ-019 ovf_err  out  1  sticky: a write was dropped.
REQ-020 udf_err  out  1  sticky: a read was dropped.

Function
REQ-021 Accepted read SHALL be defined as rd_acc = rd_en & ~empty & ~flush.
REQ-022 Accepted write SHALL be defined as wr_acc = wr_en & ~flush & (~full | rd_acc); a write while full SHALL be accepted only with a same-cycle accepted read.
REQ-023 An accepted write SHALL store wr_data at wr_ptr; wr_ptr SHALL advance by 1, wrapping FIFO_DEPTH-1 -> 0.
REQ-024 An accepted read SHALL advance rd_ptr by 1, wrapping FIFO_DEPTH-1 -> 0.
REQ-025 rd_data SHALL be combinational memory[rd_ptr] when ~empty, and all-zeros when empty.
REQ-026 There SHALL be no write-to-read bypass: data written into an empty FIFO SHALL appear on rd_data the cycle after the write.
REQ-027 A read issued while empty SHALL be ignored even if a write occurs in the same cycle.
REQ-028 count SHALL be a register updated as follows: +1 on wr_acc & ~rd_acc, -1 on rd_acc & ~wr_acc, otherwise held.
REQ-029 full, empty, afull and aempty SHALL be registers computed from the next count value, so they are valid in the same cycle as count, with zero lag.
REQ-030 flush SHALL, at the next edge, reset rd_ptr, wr_ptr and count to 0, set empty=1, full=0, and set afull and aempty per count=0; wr_en and rd_en SHALL be ignored in that cycle.
REQ-031 flush SHALL NOT clear ovf_err or udf_err, and memory contents need not be cleared.
REQ-032 ovf_err SHALL be set by wr_en & ~flush & ~wr_acc, and udf_err SHALL be set by rd_en & ~flush & empty.
REQ-033 Each error flag SHALL stay set until err_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-034 A dropped access SHALL leave pointers, count and memory unchanged.
REQ-035 Memory SHALL have no reset; only control state is reset.

Reset
REQ-036 On rst=1, the block SHALL immediately (asynchronously) apply: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, afull=(AFULL_LVL==0, i.e. 0), aempty=1, ovf_err=0, udf_err=0, and rd_data=0.
REQ-037 Reset asserted mid-operation SHALL discard all stored entries.
REQ-038 The first accepted write SHALL be possible on the first edge after rst deasserts.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-039 Scenario: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count goes 1,2,3,4; afull=1 after the 3rd write; full=1 after the 4th; aempty=0 after the 2nd; rd_data=0x11 throughout.
REQ-040 Scenario: with the FIFO full, assert wr_en alone with 0x55 -> write dropped, ovf_err=1, count=4; then assert wr_en and rd_en together with 0x66 -> pops 0x11, count stays 4, rd_data=0x22; drain yields 0x22, 0x33, 0x44, 0x66.
REQ-041 Scenario: from empty, assert wr_en and rd_en together with 0xA5 -> udf_err=1, count=1; rd_data=0xA5 in the next cycle; pulse err_clr -> udf_err=0; err_clr together with a new underflow -> udf_err stays 1.
REQ-042 Scenario: write/read 10 entries with the FIFO holding 2-3 entries -> both pointers wrap past index 3; data order is preserved; no error flags set.
REQ-043 Scenario: hold 3 entries, then assert flush together with wr_en and rd_en -> next cycle count=0, empty=1, aempty=1, afull=0; the write was not stored; error flags unchanged.
REQ-044 Scenario: assert rst asynchronously mid-stream while holding 2 entries -> outputs go to reset values before the next edge; after release, write 0x7E -> rd_data=0x7E and count=1.

Source files
------------

// File: rtl/hni_safe_fifo.sv
// Synchronous FIFO with registered occupancy flags, show-ahead read data,
// synchronous flush and sticky overflow/underflow error flags.
module hni_safe_fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AFULL_LVL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  udf_set;

  // A write into a full FIFO is only allowed when a read frees a slot the same cycle.
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign wr_acc  = wr_en & ~flush & (~full | rd_acc);
  assign ovf_set = wr_en & ~flush & ~wr_acc;
  assign udf_set = rd_en & ~flush & empty;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Flags are derived from count_nxt so they line up with count on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      count  <= count_nxt;
      full   <= (count_nxt == DEPTH_C);
      empty  <= (count_nxt == '0);
      afull  <= (count_nxt >= AFULL_C);
      aempty <= (count_nxt <= AEMPTY_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      udf_err <= udf_set | (udf_err & ~err_clr);
    end
  end

endmodule
